// File: rtl/multu_hilo.sv
// Sequential shift-and-add unsigned multiplier that owns the HI/LO register pair.
// A product takes 32 add/shift iterations plus one write-back cycle. While it runs,
// HI/LO stay reserved. MTHI/MTLO writes are accepted only when no multiply is in flight.
module multu_hilo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] writeData,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   product;
  logic [CW-1:0]        counter;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: RUN stays until all iterations are done and the write-back edge has occurred
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (counter == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath: operand latch, add/shift iterations, HI/LO write-back and MTHI/MTLO
  // The counter reaches WIDTH after the last iteration. The write-back then uses one
  // extra RUN edge, so the final sum is taken straight from the product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      counter <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hiWrite) hi <= writeData;
          if (loWrite) lo <= writeData;
          if (start) begin
            mcand   <= {{WIDTH{1'b0}}, dataA};
            mplier  <= dataB;
            product <= '0;
            counter <= '0;
          end
        end
        RUN: begin
          if (counter != LAST) begin
            if (mplier[0]) product <= product + mcand;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            counter <= counter + 1'b1;
          end else begin
            hi <= product[2*WIDTH-1:WIDTH];
            lo <= product[WIDTH-1:0];
          end
        end
        DONE: begin
          if (hiWrite) hi <= writeData;
          if (loWrite) lo <= writeData;
        end
        default: ;
      endcase
    end
  end

endmodule
